// File: rtl/mtr_comm_ctrl.sv
// mtr_comm_ctrl: BLDC commutation and duty sequencer with soft start, braking and stall/bad-hall faults.
module mtr_comm_ctrl #(
    parameter int RAMP_STEP = 8,
    parameter int STALL_PERIODS = 1024,
    parameter int BAD_HALL_LIMIT = 4,
    parameter logic [10:0] BRAKE_DUTY = 11'h400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        brake,
    input  logic        clr_fault,
    input  logic [10:0] target_duty,
    input  logic        hallGrn,
    input  logic        hallYlw,
    input  logic        hallBlu,
    input  logic        PWM_synch,
    output logic [10:0] duty,
    output logic [1:0]  selGrn,
    output logic [1:0]  selYlw,
    output logic [1:0]  selBlu,
    output logic        running,
    output logic        fault,
    output logic [15:0] comm_cnt
);
    localparam int SW = $clog2(STALL_PERIODS + 1);
    localparam int BW = $clog2(BAD_HALL_LIMIT + 1);
    typedef enum logic [2:0] {IDLE, RAMP, RUN, BRAKE, FAULT} state_t;
    state_t state, nextState;
    logic [2:0] hallMeta, hallS, hallPrev;
    logic [SW-1:0] stallCnt, stallNext;
    logic [BW-1:0] badCnt, badNext;
    logic [11:0] dutySum;
    logic [10:0] dutyStep, dutyNext;
    logic [5:0] tableSel, selNext;
    logic active, nextActive, load, hallValid, hallChange, tripFault;
    assign active = state == RAMP || state == RUN;
    assign nextActive = nextState == RAMP || nextState == RUN;
    assign load = active && PWM_synch;
    assign running = active;
    assign fault = state == FAULT;
    assign hallValid = hallS != 3'b000 && hallS != 3'b111;
    assign hallChange = hallValid && hallS != hallPrev;
    assign stallNext = hallChange ? '0 : stallCnt + 1'b1;
    assign badNext = hallValid ? '0 : badCnt + 1'b1;
    assign tripFault = load && (stallNext == SW'(STALL_PERIODS) || badNext == BW'(BAD_HALL_LIMIT));
    // Up-ramp saturates at target; any target at or below duty is taken immediately.
    assign dutySum = {1'b0, duty} + 12'(RAMP_STEP);
    assign dutyStep = (duty < target_duty && dutySum < {1'b0, target_duty}) ? dutySum[10:0] : target_duty;
    always_comb begin
        tableSel = 6'b00_00_00;
        case (hallS)
            3'b101: tableSel = 6'b10_01_00;
            3'b100: tableSel = 6'b10_00_01;
            3'b110: tableSel = 6'b00_10_01;
            3'b010: tableSel = 6'b01_10_00;
            3'b011: tableSel = 6'b01_00_10;
            3'b001: tableSel = 6'b00_01_10;
            default: tableSel = 6'b00_00_00;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nextState;
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = brake ? BRAKE : go ? RAMP : IDLE;
            RAMP, RUN: nextState = tripFault ? FAULT : brake ? BRAKE : !go ? IDLE :
                (state == RAMP && PWM_synch && dutyStep == target_duty) ? RUN : state;
            BRAKE: nextState = brake ? BRAKE : IDLE;
            FAULT: nextState = (clr_fault && !go) ? IDLE : FAULT;
            default: nextState = IDLE;
        endcase
    end
    // Safe states force their outputs on entry; RAMP/RUN only move on PWM period starts.
    always_comb begin
        dutyNext = duty;
        selNext = {selGrn, selYlw, selBlu};
        case (nextState)
            IDLE, FAULT: begin
                dutyNext = '0;
                selNext = '0;
            end
            BRAKE: begin
                dutyNext = BRAKE_DUTY;
                selNext = '1;
            end
            default: if (load) begin
                dutyNext = dutyStep;
                selNext = tableSel;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hallMeta <= '0;
            hallS <= '0;
            hallPrev <= '0;
            stallCnt <= '0;
            badCnt <= '0;
            duty <= '0;
            {selGrn, selYlw, selBlu} <= '0;
            comm_cnt <= '0;
        end else begin
            hallMeta <= {hallGrn, hallYlw, hallBlu};
            hallS <= hallMeta;
            if (PWM_synch) hallPrev <= hallS;
            if (!nextActive) begin
                stallCnt <= '0;
                badCnt <= '0;
            end else if (load) begin
                stallCnt <= stallNext;
                badCnt <= badNext;
            end
            if (load && hallChange) comm_cnt <= comm_cnt + 1'b1;
            duty <= dutyNext;
            {selGrn, selYlw, selBlu} <= selNext;
        end
endmodule

// File: tb/tb_mtr_comm_ctrl.sv
// tb_mtr_comm_ctrl: scenario bench for mtr_comm_ctrl with a queue of expected duty/select values.
module tb_mtr_comm_ctrl;
    logic clk = 0, rst_n = 0, go = 0, brake = 0, clr_fault = 0, PWM_synch = 0;
    logic hallGrn = 0, hallYlw = 0, hallBlu = 0;
    logic [10:0] target_duty = 0, duty;
    logic [1:0] selGrn, selYlw, selBlu;
    logic running, fault;
    logic [15:0] comm_cnt;
    int errors = 0, checks = 0;
    typedef struct {
        logic [10:0] duty;
        logic [5:0] sel;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    mtr_comm_ctrl #(.RAMP_STEP(8), .STALL_PERIODS(16), .BAD_HALL_LIMIT(4), .BRAKE_DUTY(11'h400)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .brake(brake), .clr_fault(clr_fault),
        .target_duty(target_duty), .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
        .PWM_synch(PWM_synch), .duty(duty), .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
        .running(running), .fault(fault), .comm_cnt(comm_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] selOf(input logic [2:0] h);
        case (h)
            3'b101: return 6'b10_01_00;
            3'b100: return 6'b10_00_01;
            3'b110: return 6'b00_10_01;
            3'b010: return 6'b01_10_00;
            3'b011: return 6'b01_00_10;
            3'b001: return 6'b00_01_10;
            default: return 6'b00_00_00;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        PWM_synch = 1;
        @(negedge clk);
        PWM_synch = 0;
    endtask

    task automatic setHall(input logic [2:0] h);
        {hallGrn, hallYlw, hallBlu} = h;
        tick(3);
    endtask

    task automatic test_reset();
        go = 1;
        for (int i = 0; i < 6; i++) begin
            {hallGrn, hallYlw, hallBlu} = 3'($urandom_range(0, 7));
            PWM_synch = i[0];
            @(negedge clk);
        end
        PWM_synch = 0;
        checks++;
        if ({duty, selGrn, selYlw, selBlu, running, fault, comm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_hold: duty=%h sel=%b%b%b run=%b fault=%b comm=%0d, required all zero", duty, selGrn, selYlw, selBlu, running, fault, comm_cnt);
        end
        go = 0;
        rst_n = 1;
        tick(3);
        checks++;
        if ({duty, selGrn, selYlw, selBlu, running, fault, comm_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_release: duty=%h sel=%b%b%b run=%b fault=%b comm=%0d, required all zero", duty, selGrn, selYlw, selBlu, running, fault, comm_cnt);
        end
    endtask

    task automatic test_ramp();
        target_duty = 100;
        setHall(3'b101);
        go = 1;
        tick(1);
        checks++;
        if (running !== 1'b1 || duty !== 11'd0) begin
            errors++;
            $display("FAIL ramp_entry: running=%b duty=%0d, required running=1 duty=0", running, duty);
        end
        for (int k = 1; k <= 13; k++) sb.push_back('{11'((8 * k < 100) ? 8 * k : 100), 6'b10_01_00});
        for (int k = 1; k <= 13; k++) begin
            pulse();
            e = sb.pop_front();
            checks++;
            if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel || running !== 1'b1) begin
                errors++;
                $display("FAIL ramp_step%0d: duty=%0d sel=%b%b%b run=%b, required duty=%0d sel=%b run=1", k, duty, selGrn, selYlw, selBlu, running, e.duty, e.sel);
            end
        end
        target_duty = 40;
        sb.push_back('{11'd40, 6'b10_01_00});
        pulse();
        e = sb.pop_front();
        checks++;
        if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel) begin
            errors++;
            $display("FAIL run_drop_target: duty=%0d sel=%b%b%b, required duty=%0d sel=%b", duty, selGrn, selYlw, selBlu, e.duty, e.sel);
        end
        checks++;
        if (comm_cnt !== 16'd1) begin
            errors++;
            $display("FAIL ramp_comm_cnt: comm_cnt=%0d, required 1", comm_cnt);
        end
    endtask

    task automatic test_commutate();
        logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
        for (int i = 0; i < 6; i++) begin
            setHall(seq[i]);
            sb.push_back('{11'd40, selOf(seq[i])});
            pulse();
            e = sb.pop_front();
            checks++;
            if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel || fault !== 1'b0) begin
                errors++;
                $display("FAIL commutate_%b: duty=%0d sel=%b%b%b fault=%b, required duty=%0d sel=%b fault=0", seq[i], duty, selGrn, selYlw, selBlu, fault, e.duty, e.sel);
            end
        end
        checks++;
        if (comm_cnt !== 16'd6) begin
            errors++;
            $display("FAIL commutate_count: comm_cnt=%0d, required 6", comm_cnt);
        end
    endtask

    task automatic test_stall();
        setHall(3'b101);
        pulse();
        for (int i = 1; i <= 16; i++) sb.push_back(i < 16 ? '{11'd40, 6'b10_01_00} : '{11'd0, 6'b0});
        for (int i = 1; i <= 16; i++) begin
            pulse();
            e = sb.pop_front();
            checks++;
            if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel || fault !== (i == 16)) begin
                errors++;
                $display("FAIL stall_period%0d: duty=%0d sel=%b%b%b fault=%b, required duty=%0d sel=%b fault=%b", i, duty, selGrn, selYlw, selBlu, fault, e.duty, e.sel, i == 16);
            end
        end
        checks++;
        if (running !== 1'b0 || comm_cnt !== 16'd7) begin
            errors++;
            $display("FAIL stall_state: running=%b comm_cnt=%0d, required running=0 comm_cnt=7", running, comm_cnt);
        end
        clr_fault = 1;
        brake = 1;
        tick(2);
        pulse();
        checks++;
        if (fault !== 1'b1 || duty !== 11'd0 || {selGrn, selYlw, selBlu} !== 6'b0) begin
            errors++;
            $display("FAIL fault_hold: fault=%b duty=%0d sel=%b%b%b, required fault=1 duty=0 sel=000000", fault, duty, selGrn, selYlw, selBlu);
        end
        brake = 0;
        go = 0;
        tick(1);
        clr_fault = 0;
        checks++;
        if (fault !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: fault=%b running=%b, required fault=0 running=0", fault, running);
        end
    endtask

    task automatic test_bad_hall();
        logic [2:0] seq [13] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111,
                                 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
        setHall(3'b110);
        go = 1;
        tick(1);
        for (int i = 0; i < 13; i++)
            sb.push_back(i == 12 ? '{11'd0, 6'b0} : '{11'(i < 5 ? 8 * (i + 1) : 40), selOf(seq[i])});
        for (int i = 0; i < 13; i++) begin
            if (i >= 5) setHall(seq[i]);
            pulse();
            e = sb.pop_front();
            checks++;
            if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel || fault !== (i == 12)) begin
                errors++;
                $display("FAIL bad_hall_%0d: duty=%0d sel=%b%b%b fault=%b, required duty=%0d sel=%b fault=%b", i, duty, selGrn, selYlw, selBlu, fault, e.duty, e.sel, i == 12);
            end
        end
        checks++;
        if (comm_cnt !== 16'd9) begin
            errors++;
            $display("FAIL bad_hall_count: comm_cnt=%0d, required 9", comm_cnt);
        end
        go = 0;
        clr_fault = 1;
        tick(1);
        clr_fault = 0;
    endtask

    task automatic test_brake();
        setHall(3'b100);
        go = 1;
        tick(1);
        for (int k = 1; k <= 5; k++) sb.push_back('{11'(8 * k), 6'b10_00_01});
        for (int k = 1; k <= 5; k++) begin
            pulse();
            e = sb.pop_front();
            checks++;
            if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel) begin
                errors++;
                $display("FAIL brake_ramp%0d: duty=%0d sel=%b%b%b, required duty=%0d sel=%b", k, duty, selGrn, selYlw, selBlu, e.duty, e.sel);
            end
        end
        brake = 1;
        tick(1);
        checks++;
        if (duty !== 11'h400 || {selGrn, selYlw, selBlu} !== 6'b111111 || running !== 1'b0) begin
            errors++;
            $display("FAIL brake_apply: duty=%h sel=%b%b%b run=%b, required duty=400 sel=111111 run=0", duty, selGrn, selYlw, selBlu, running);
        end
        brake = 0;
        tick(1);
        checks++;
        if (duty !== 11'd0 || {selGrn, selYlw, selBlu} !== 6'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL brake_release: duty=%0d sel=%b%b%b run=%b, required duty=0 sel=000000 run=0", duty, selGrn, selYlw, selBlu, running);
        end
        tick(1);
        sb.push_back('{11'd8, 6'b10_00_01});
        pulse();
        e = sb.pop_front();
        checks++;
        if (duty !== e.duty || {selGrn, selYlw, selBlu} !== e.sel || running !== 1'b1) begin
            errors++;
            $display("FAIL brake_reramp: duty=%0d sel=%b%b%b run=%b, required duty=%0d sel=%b run=1", duty, selGrn, selYlw, selBlu, running, e.duty, e.sel);
        end
        checks++;
        if (comm_cnt !== 16'd10) begin
            errors++;
            $display("FAIL brake_count: comm_cnt=%0d, required 10", comm_cnt);
        end
    endtask

    task automatic test_go_drop();
        go = 0;
        pulse();
        checks++;
        if (duty !== 11'd0 || {selGrn, selYlw, selBlu} !== 6'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL go_drop_on_synch: duty=%0d sel=%b%b%b run=%b, required duty=0 sel=000000 run=0", duty, selGrn, selYlw, selBlu, running);
        end
        go = 1;
        tick(1);
        pulse();
        checks++;
        if (duty !== 11'd8 || running !== 1'b1) begin
            errors++;
            $display("FAIL go_restart: duty=%0d run=%b, required duty=8 run=1", duty, running);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({duty, selGrn, selYlw, selBlu, running, fault, comm_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: duty=%0d sel=%b%b%b run=%b fault=%b comm=%0d, required all zero", duty, selGrn, selYlw, selBlu, running, fault, comm_cnt);
        end
        go = 0;
        tick(1);
        rst_n = 1;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_ramp();
        test_commutate();
        test_stall();
        test_bad_hall();
        test_brake();
        test_go_drop();
        test_async_reset();
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mtr_comm_ctrl.md
Name: mtr_comm_ctrl

Overview:
Commutation and duty sequencer for the BLDC motor drive. It synchronizes the three hall sensors and produces the per-coil selects (selGrn/selYlw/selBlu) and the 11-bit duty that feed the motor-drive/PWM/nonoverlap datapath. Updates are aligned to the PWM period boundary (PWM_synch). The block also provides soft-start duty ramping, braking, and stall/bad-hall fault detection.

Parameters:
RAMP_STEP, 8, duty increment per PWM period while ramping up (1..2047)
STALL_PERIODS, 1024, consecutive PWM periods with no hall change in RAMP/RUN that trips a fault
BAD_HALL_LIMIT, 4, consecutive invalid hall samples (000/111) that trip a fault
BRAKE_DUTY, 11'h400, duty driven while braking

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
go  input  1  run request (level)
brake  input  1  brake request (level); overrides go
clr_fault  input  1  fault clear (level, honoured only with go=0)
target_duty  input  11  requested running duty
hallGrn  input  1  hall sensor, asynchronous
hallYlw  input  1  hall sensor, asynchronous
hallBlu  input  1  hall sensor, asynchronous
PWM_synch  input  1  one-clk pulse at PWM period start (from motor drive)
duty  output  11  duty to PWM
selGrn  output  2  coil select
selYlw  output  2  coil select
selBlu  output  2  coil select
running  output  1  state is RAMP or RUN
fault  output  1  state is FAULT
comm_cnt  output  16  count of valid commutations

Behaviour:
- Reset (async): state IDLE; duty=0; all sel=00; running=0; fault=0; comm_cnt=0; sync flops, hall_prev, stall and bad counters=0.
- Select encoding: 00 coast, 01 reverse, 10 forward, 11 brake.
- Hall path: each hall input passes through a 2-flop synchronizer giving hall_s = {Grn,Ylw,Blu}. hall_prev is loaded from hall_s on each PWM_synch cycle.
- Commutation table (hall_s -> Grn,Ylw,Blu):
  - 101 -> 10,01,00
  - 100 -> 10,00,01
  - 110 -> 00,10,01
  - 010 -> 01,10,00
  - 011 -> 01,00,10
  - 001 -> 00,01,10
  - 000/111 -> 00,00,00
- Output timing:
  - In RAMP/RUN, sel and duty load only on clock edges where PWM_synch=1.
  - Entry into IDLE, BRAKE or FAULT loads safe values on the same edge as the state change; outputs are valid the next cycle.
- Transition priority, per edge: fault condition > brake > go.
- IDLE:
  - Outputs: sel=00, duty=0.
  - brake=1 -> BRAKE.
  - Else go=1 -> RAMP.
- RAMP:
  - On PWM_synch, sel is loaded from the table using hall_s.
  - On PWM_synch, duty=min(duty+RAMP_STEP, target_duty), computed 12-bit and saturated.
  - When the loaded duty equals target_duty -> RUN.
- RUN:
  - On PWM_synch, sel is loaded from the table.
  - If target_duty > duty: duty=min(duty+RAMP_STEP, target_duty).
  - Otherwise: duty=target_duty immediately (no down-ramp).
- Both RAMP and RUN:
  - go=0 -> IDLE.
  - brake=1 -> BRAKE.
- BRAKE:
  - Outputs: all sel=11, duty=BRAKE_DUTY.
  - brake=0 -> IDLE, even if go=1; a re-ramp starts from duty 0 on the next edge.
- FAULT:
  - Outputs: sel=00, duty=0, fault=1.
  - Exit to IDLE only when clr_fault=1 and go=0.
  - go/brake are otherwise ignored.
- Stall detection (RAMP/RUN only), on each PWM_synch:
  - hall_s valid and != hall_prev: stall counter cleared; comm_cnt increments, wrapping FFFF->0000.
  - Otherwise: stall counter increments.
  - Reaching STALL_PERIODS -> FAULT.
  - Counter is cleared on entry to RAMP.
- Bad-hall detection (RAMP/RUN only), on each PWM_synch:
  - hall_s in {000,111}: bad counter increments and sel loads 00.
  - Valid sample: bad counter clears.
  - Reaching BAD_HALL_LIMIT -> FAULT.
- comm_cnt: cleared only by reset.
- PWM_synch in the same cycle as go falling: go=0 wins; state goes to IDLE with safe outputs.
- rst_n asserted mid-operation: all outputs drop to reset values asynchronously.

Test Plan:
1. Hold rst_n=0 with go=1 and toggling halls -> duty=0, sel=00/00/00, fault=0, comm_cnt=0. Release with go=0 -> outputs stay 0.
2. go=1, target_duty=100, RAMP_STEP=8, hall=101 -> on successive PWM_synch duty goes 8,16,...,96,100 (13 pulses); sel=10/01/00 from the first pulse; RUN after the 13th; running=1. Then target_duty=40 -> duty=40 on the next PWM_synch.
3. In RUN, step hall through 101,100,110,010,011,001, one per PWM period -> sel follows the table each period; comm_cnt=6; no fault.
4. STALL_PERIODS=16, hall held at 101 in RUN -> fault=1, sel=00, duty=0 the cycle after the 16th PWM_synch. clr_fault=1 with go=1 -> stays FAULT; go=0 -> IDLE.
5. BAD_HALL_LIMIT=4: hall=111 for 3 periods then 101 -> sel=00 for 3 periods, then the table value, no fault. hall=000 for 4 periods -> FAULT.
6. go=1 and brake=1 in RUN -> next cycle sel=11/11/11, duty=0x400, running=0. brake=0 -> IDLE, then RAMP from duty 0.
